// File: rtl/commit_trace_buffer_if.sv
// Commit-trace bus: core commit inputs, run control, trace drain handshake
// and status outputs of commit_trace_buffer.
interface commit_trace_buffer_if #(
   parameter int NCOMMIT = 2,
   parameter int DEPTH   = 16,
   parameter int CNT_W   = 32
);
   logic                         io_in_start;
   logic [NCOMMIT-1:0]           io_in_commit_valid;
   logic [NCOMMIT*32-1:0]        io_in_commit_pc;
   logic [NCOMMIT*32-1:0]        io_in_commit_inst;
   logic                         io_out_trace_valid;
   logic                         io_out_trace_ready;
   logic [31:0]                  io_out_trace_pc;
   logic [31:0]                  io_out_trace_inst;
   logic [1:0]                   io_out_state;
   logic [CNT_W-1:0]             io_out_cycles;
   logic [CNT_W-1:0]             io_out_insts;
   logic                         io_out_overflow;
   logic [$clog2(DEPTH+1)-1:0]   io_out_count;

   // Harness/core side.
   modport master (
      output io_in_start, io_in_commit_valid, io_in_commit_pc, io_in_commit_inst,
      output io_out_trace_ready,
      input  io_out_trace_valid, io_out_trace_pc, io_out_trace_inst,
      input  io_out_state, io_out_cycles, io_out_insts, io_out_overflow, io_out_count
   );

   // Trace buffer side.
   modport slave (
      input  io_in_start, io_in_commit_valid, io_in_commit_pc, io_in_commit_inst,
      input  io_out_trace_ready,
      output io_out_trace_valid, io_out_trace_pc, io_out_trace_inst,
      output io_out_state, io_out_cycles, io_out_insts, io_out_overflow, io_out_count
   );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retired instructions from a multi-commit core
// into an in-order FIFO drained by the harness, runs an IDLE/RUN/HALT/TIMEOUT
// state machine and keeps cycle and instruction counters.
module commit_trace_buffer #(
   parameter int          NCOMMIT        = 2,
   parameter int          DEPTH          = 16,
   parameter int          CNT_W          = 32,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] HALT_INST      = 32'h00100073
) (
   input  logic                   clock,
   input  logic                   reset,
   commit_trace_buffer_if.slave   bus
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int OCC_W  = $clog2(DEPTH + 1);
   localparam int N_W    = $clog2(NCOMMIT + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALT    = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [31:0]        r_mem_pc   [DEPTH];
   logic [31:0]        r_mem_inst [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [OCC_W-1:0]   r_count;
   logic               r_overflow;
   logic [CNT_W-1:0]   r_cycles;
   logic [CNT_W-1:0]   r_insts;
   logic [IDLE_W-1:0]  r_idle;

   logic [NCOMMIT-1:0] w_accept;
   logic [PTR_W-1:0]   w_off [NCOMMIT];
   logic [N_W-1:0]     w_n;
   logic [N_W-1:0]     w_push_n;
   logic               w_halt_hit;
   logic               w_any_valid;
   logic               w_fit;
   logic               w_valid;
   logic               w_pop;
   logic               w_restart;
   logic               w_enter_run;
   logic               w_timeout_hit;
   logic [CNT_W:0]     w_insts_sum;

   // Build the accepted set: valid channels in order, truncated after the first halt.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves it unassigned and no latch is inferred.
      w_accept   = '0;
      w_halt_hit = 1'b0;
      w_n        = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
         w_off[i] = '0;
         if ((r_state == S_RUN) && bus.io_in_commit_valid[i] && !w_halt_hit) begin
            w_accept[i] = 1'b1;
            w_off[i]    = PTR_W'(w_n);
            w_n         = w_n + N_W'(1);
            if (bus.io_in_commit_inst[32*i +: 32] == HALT_INST) begin
               w_halt_hit = 1'b1;
            end
         end
      end
   end

   // Derived control: space check, pop, restart and timeout conditions.
   always_comb begin
      w_any_valid   = (r_state == S_RUN) && (|bus.io_in_commit_valid);
      // Pre-edge occupancy only; a pop this cycle does not make room.
      w_fit         = (32'(w_n) + 32'(r_count)) <= 32'(DEPTH);
      w_push_n      = w_fit ? w_n : '0;
      w_valid       = (r_count != '0);
      w_pop         = w_valid && bus.io_out_trace_ready;
      w_restart     = bus.io_in_start && ((r_state == S_HALT) || (r_state == S_TIMEOUT));
      w_timeout_hit = !w_any_valid && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));
      w_insts_sum   = {1'b0, r_insts} + (CNT_W + 1)'(w_n);
   end

   // Next-state logic of the run state machine.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (bus.io_in_start) w_next_state = S_RUN;
         S_RUN: begin
            // A halt always carries a commit, so it cannot coincide with a timeout.
            if (w_halt_hit)         w_next_state = S_HALT;
            else if (w_timeout_hit) w_next_state = S_TIMEOUT;
         end
         S_HALT,
         S_TIMEOUT: if (bus.io_in_start) w_next_state = S_RUN;
         default:   w_next_state = S_IDLE;
      endcase
      w_enter_run = (r_state != S_RUN) && (w_next_state == S_RUN);
   end

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // FIFO storage writes; accepted entries land at consecutive slots from the write pointer.
   always_ff @(posedge clock) begin
      // NOTE: the storage array has no reset; occupancy alone decides what is
      // visible, and the empty-head outputs are forced to zero below.
      for (int i = 0; i < NCOMMIT; i++) begin
         if (w_accept[i] && w_fit) begin
            r_mem_pc[r_wr_ptr + w_off[i]]   <= bus.io_in_commit_pc[32*i +: 32];
            r_mem_inst[r_wr_ptr + w_off[i]] <= bus.io_in_commit_inst[32*i +: 32];
         end
      end
   end

   // FIFO pointers, occupancy and sticky overflow; restart flushes everything.
   always_ff @(posedge clock) begin
      if (reset || w_restart) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
         r_count  <= r_count + OCC_W'(w_push_n) - OCC_W'(w_pop);
         if (!w_fit) r_overflow <= 1'b1;
      end
   end

   // Saturating RUN-cycle and accepted-instruction counters.
   always_ff @(posedge clock) begin
      if (reset || w_restart) begin
         r_cycles <= '0;
         r_insts  <= '0;
      end else if (r_state == S_RUN) begin
         if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
         r_insts <= w_insts_sum[CNT_W] ? '1 : w_insts_sum[CNT_W-1:0];
      end
   end

   // Idle counter: consecutive commit-less RUN cycles since entry or the last commit.
   always_ff @(posedge clock) begin
      if (reset || w_restart || w_enter_run) begin
         r_idle <= '0;
      end else if (r_state == S_RUN) begin
         if (w_any_valid) r_idle <= '0;
         else             r_idle <= r_idle + IDLE_W'(1);
      end
   end

   // Output drive: head entry or zeros when empty, registered status.
   always_comb begin
      bus.io_out_trace_valid = w_valid;
      bus.io_out_trace_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;
      bus.io_out_trace_inst  = w_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
      bus.io_out_state       = r_state;
      bus.io_out_cycles      = r_cycles;
      bus.io_out_insts       = r_insts;
      bus.io_out_overflow    = r_overflow;
      bus.io_out_count       = r_count;
   end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed testbench for commit_trace_buffer (NCOMMIT=2, DEPTH=16, TIMEOUT_CYCLES=8).
module tb_commit_trace_buffer;

   localparam logic [31:0] HALT = 32'h00100073;
   localparam logic [31:0] NOP  = 32'h00000013;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   commit_trace_buffer_if #(.NCOMMIT(2), .DEPTH(16), .CNT_W(32)) bus ();

   commit_trace_buffer #(
      .NCOMMIT(2), .DEPTH(16), .CNT_W(32), .TIMEOUT_CYCLES(8), .HALT_INST(HALT)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                        input logic [31:0] pc1, input logic [31:0] i1);
      bus.io_in_commit_valid = v;
      bus.io_in_commit_pc    = {pc1, pc0};
      bus.io_in_commit_inst  = {i1, i0};
   endtask

   task automatic reset_start();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.io_in_start = 1'b1;
      tick();
      bus.io_in_start = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_state"},    32'(bus.io_out_state), 32'd0);
      check({tag, "_count"},    32'(bus.io_out_count), 32'd0);
      check({tag, "_valid"},    32'(bus.io_out_trace_valid), 32'd0);
      check({tag, "_pc"},       bus.io_out_trace_pc, 32'd0);
      check({tag, "_inst"},     bus.io_out_trace_inst, 32'd0);
      check({tag, "_cycles"},   bus.io_out_cycles, 32'd0);
      check({tag, "_insts"},    bus.io_out_insts, 32'd0);
      check({tag, "_overflow"}, 32'(bus.io_out_overflow), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.io_in_start = 1'b0;
      bus.io_out_trace_ready = 1'b0;
      drive(2'b00, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_reset_state("rst");

      // Single commit, then drain; start during RUN must be ignored.
      bus.io_in_start = 1'b1;
      tick();
      bus.io_in_start = 1'b0;
      check("t1_run", 32'(bus.io_out_state), 32'd1);
      check("t1_cyc0", bus.io_out_cycles, 32'd0);
      drive(2'b01, 32'h8000_0000, NOP, 0, 0);
      tick();
      drive(2'b00, 0, 0, 0, 0);
      check("t1_valid", 32'(bus.io_out_trace_valid), 32'd1);
      check("t1_pc", bus.io_out_trace_pc, 32'h8000_0000);
      check("t1_inst", bus.io_out_trace_inst, NOP);
      check("t1_insts", bus.io_out_insts, 32'd1);
      check("t1_count", 32'(bus.io_out_count), 32'd1);
      bus.io_out_trace_ready = 1'b1;
      bus.io_in_start = 1'b1;
      tick();
      bus.io_out_trace_ready = 1'b0;
      bus.io_in_start = 1'b0;
      check("t1_drained", 32'(bus.io_out_count), 32'd0);
      check("t1_empty_pc", bus.io_out_trace_pc, 32'd0);
      check("t1_cycles", bus.io_out_cycles, 32'd2);
      check("t1_insts_kept", bus.io_out_insts, 32'd1);

      // Dual commit drains in channel order; a gap mask enqueues only ch1.
      reset_start();
      drive(2'b11, 32'h100, NOP, 32'h104, NOP);
      tick();
      drive(2'b00, 0, 0, 0, 0);
      check("t2_count", 32'(bus.io_out_count), 32'd2);
      check("t2_insts", bus.io_out_insts, 32'd2);
      bus.io_out_trace_ready = 1'b1;
      check("t2_head0", bus.io_out_trace_pc, 32'h100);
      tick();
      check("t2_head1", bus.io_out_trace_pc, 32'h104);
      tick();
      bus.io_out_trace_ready = 1'b0;
      check("t2_empty", 32'(bus.io_out_trace_valid), 32'd0);
      drive(2'b10, 32'h100, NOP, 32'h104, NOP);
      tick();
      drive(2'b00, 0, 0, 0, 0);
      check("t2_gap_count", 32'(bus.io_out_count), 32'd1);
      check("t2_gap_pc", bus.io_out_trace_pc, 32'h104);
      check("t2_gap_insts", bus.io_out_insts, 32'd3);

      // Overflow: nine dual-commit cycles into a 16-entry FIFO.
      reset_start();
      for (int k = 0; k < 9; k++) begin
         drive(2'b11, 32'h1000 + 32'(8*k), NOP, 32'h1004 + 32'(8*k), NOP);
         tick();
         if (k == 7) begin
            check("t3_full", 32'(bus.io_out_count), 32'd16);
            check("t3_no_ovf_yet", 32'(bus.io_out_overflow), 32'd0);
         end
      end
      drive(2'b00, 0, 0, 0, 0);
      check("t3_count", 32'(bus.io_out_count), 32'd16);
      check("t3_overflow", 32'(bus.io_out_overflow), 32'd1);
      check("t3_insts", bus.io_out_insts, 32'd18);
      check("t3_cycles", bus.io_out_cycles, 32'd9);
      bus.io_out_trace_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         check($sformatf("t3_drain%0d", j), bus.io_out_trace_pc, 32'h1000 + 32'(4*j));
         tick();
      end
      bus.io_out_trace_ready = 1'b0;
      check("t3_drained", 32'(bus.io_out_count), 32'd0);
      // Eight commit-less RUN cycles elapsed during the drain.
      check("t3_timeout", 32'(bus.io_out_state), 32'd3);
      check("t3_cyc_final", bus.io_out_cycles, 32'd17);
      bus.io_in_start = 1'b1;
      tick();
      bus.io_in_start = 1'b0;
      check("t3_rs_state", 32'(bus.io_out_state), 32'd1);
      check("t3_rs_ovf", 32'(bus.io_out_overflow), 32'd0);
      check("t3_rs_insts", bus.io_out_insts, 32'd0);
      check("t3_rs_cycles", bus.io_out_cycles, 32'd0);

      // Halt on ch0 discards ch1; later commits ignored; restart flushes.
      reset_start();
      drive(2'b01, 32'h300, NOP, 0, 0);
      tick();
      drive(2'b11, 32'h304, HALT, 32'h308, NOP);
      tick();
      check("t4_state", 32'(bus.io_out_state), 32'd2);
      check("t4_insts", bus.io_out_insts, 32'd2);
      check("t4_count", 32'(bus.io_out_count), 32'd2);
      drive(2'b11, 32'h400, NOP, 32'h404, NOP);
      tick();
      drive(2'b00, 0, 0, 0, 0);
      check("t4_ign_count", 32'(bus.io_out_count), 32'd2);
      check("t4_ign_insts", bus.io_out_insts, 32'd2);
      check("t4_ign_cycles", bus.io_out_cycles, 32'd2);
      check("t4_head0", bus.io_out_trace_pc, 32'h300);
      bus.io_out_trace_ready = 1'b1;
      tick();
      bus.io_out_trace_ready = 1'b0;
      check("t4_head1_pc", bus.io_out_trace_pc, 32'h304);
      check("t4_head1_inst", bus.io_out_trace_inst, HALT);
      check("t4_left", 32'(bus.io_out_count), 32'd1);
      bus.io_in_start = 1'b1;
      tick();
      bus.io_in_start = 1'b0;
      check("t4_rs_state", 32'(bus.io_out_state), 32'd1);
      check("t4_rs_count", 32'(bus.io_out_count), 32'd0);
      check("t4_rs_valid", 32'(bus.io_out_trace_valid), 32'd0);
      check("t4_rs_insts", bus.io_out_insts, 32'd0);
      check("t4_rs_cycles", bus.io_out_cycles, 32'd0);
      // Halt on ch1 keeps the older ch0.
      drive(2'b11, 32'h500, NOP, 32'h504, HALT);
      tick();
      drive(2'b00, 0, 0, 0, 0);
      check("t4_h1_insts", bus.io_out_insts, 32'd2);
      check("t4_h1_count", 32'(bus.io_out_count), 32'd2);
      check("t4_h1_state", 32'(bus.io_out_state), 32'd2);

      // Timeout after exactly 8 commit-less RUN cycles.
      reset_start();
      for (int k = 0; k < 7; k++) tick();
      check("t5_still_run", 32'(bus.io_out_state), 32'd1);
      tick();
      check("t5_timeout", 32'(bus.io_out_state), 32'd3);
      check("t5_cycles", bus.io_out_cycles, 32'd8);
      // A commit on the 7th idle cycle restarts the window.
      reset_start();
      for (int k = 0; k < 6; k++) tick();
      drive(2'b01, 32'h600, NOP, 0, 0);
      tick();
      drive(2'b00, 0, 0, 0, 0);
      for (int k = 0; k < 7; k++) tick();
      check("t5_window_run", 32'(bus.io_out_state), 32'd1);
      check("t5_window_cyc", bus.io_out_cycles, 32'd14);
      tick();
      check("t5_window_to", 32'(bus.io_out_state), 32'd3);
      check("t5_window_cyc2", bus.io_out_cycles, 32'd15);
      check("t5_window_insts", bus.io_out_insts, 32'd1);

      // Reset with an overflowed full FIFO in RUN.
      reset_start();
      for (int k = 0; k < 9; k++) begin
         drive(2'b11, 32'h2000 + 32'(8*k), NOP, 32'h2004 + 32'(8*k), NOP);
         tick();
      end
      drive(2'b00, 0, 0, 0, 0);
      check("t6_pre_count", 32'(bus.io_out_count), 32'd16);
      check("t6_pre_ovf", 32'(bus.io_out_overflow), 32'd1);
      rst = 1'b1;
      bus.io_in_start = 1'b1;
      tick();
      rst = 1'b0;
      bus.io_in_start = 1'b0;
      check_reset_state("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
